// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: measurement result bus of pwm_decoder.
//   duty_r/g/b  : high-cycle counts of the last completed window (producer -> consumer)
//   active      : per-channel edge-seen flags, bit2=R bit1=G bit0=B (producer -> consumer)
//   duty_valid  : a new measurement set is being held (producer -> consumer)
//   duty_ready  : consumer accepts the set; transfer on duty_valid && duty_ready
//   overrun     : sticky, a set was overwritten before it was transferred
// Modports: master = decoder side, slave = consumer side.
interface pwm_decoder_if #(
  parameter int unsigned CNT_W = 11
);
  logic [CNT_W-1:0] duty_r;
  logic [CNT_W-1:0] duty_g;
  logic [CNT_W-1:0] duty_b;
  logic [2:0]       active;
  logic             duty_valid;
  logic             duty_ready;
  logic             overrun;

  modport master (
    output duty_r,
    output duty_g,
    output duty_b,
    output active,
    output duty_valid,
    output overrun,
    input  duty_ready
  );

  modport slave (
    input  duty_r,
    input  duty_g,
    input  duty_b,
    input  active,
    input  duty_valid,
    input  overrun,
    output duty_ready
  );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures the duty (high-cycle count) of three PWM inputs (R, G, B) over
// fixed windows of PWM_INTERVAL clock cycles and presents each completed set on a
// valid/ready bus.
//
// Ports:
//   clk     : system clock, all state changes on the rising edge
//   rst_n   : asynchronous active-low reset
//   pwm_in  : PWM samples, bit2=R bit1=G bit0=B
//   meas    : pwm_decoder_if master (duty_r/g/b, active, duty_valid, duty_ready, overrun)
//
// Configuration:
//   PWM_DECODER_SYNC_EN : when defined, each pwm_in bit passes through a 2-flop
//                         synchronizer (2 cycles of input latency); otherwise pwm_in is
//                         sampled directly.
//
// Parameters:
//   PWM_INTERVAL : window length in cycles (one PWM period)
//   CNT_W        : counter width, must satisfy 2**CNT_W > PWM_INTERVAL
module pwm_decoder #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned CNT_W        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    pwm_in,
  pwm_decoder_if.master meas
);

  localparam logic [CNT_W-1:0] WinLast = CNT_W'(PWM_INTERVAL - 1);

  // Channel index follows pwm_in bit order: 2=R, 1=G, 0=B.
  logic [2:0] s;

`ifdef PWM_DECODER_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = pwm_in;
`endif

  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] acc_q   [3];
  logic [CNT_W-1:0] acc_d   [3];
  logic [CNT_W-1:0] acc_sum [3];
  logic [CNT_W-1:0] duty_q  [3];
  logic [CNT_W-1:0] duty_d  [3];
  logic [2:0]       prev_q;
  logic [2:0]       edge_seen_q, edge_seen_d;
  logic [2:0]       active_q, active_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             win_end;
  logic [2:0]       edge_now;
  logic             xfer;

  always_comb begin
    win_end     = (win_cnt_q == WinLast);
    edge_now    = s ^ prev_q;
    xfer        = valid_q & meas.duty_ready;
    win_cnt_d   = win_end ? '0 : win_cnt_q + CNT_W'(1);
    edge_seen_d = win_end ? '0 : (edge_seen_q | edge_now);
    active_d    = win_end ? (edge_seen_q | edge_now) : active_q;

    for (int ch = 0; ch < 3; ch++) begin
      // Includes the current sample so the final cycle of the window is counted; the
      // sum is at most PWM_INTERVAL, which fits in CNT_W bits.
      acc_sum[ch] = acc_q[ch] + CNT_W'(s[ch]);
      acc_d[ch]   = win_end ? '0 : acc_sum[ch];
      duty_d[ch]  = win_end ? acc_sum[ch] : duty_q[ch];
    end

    // A window end always leaves a fresh set pending, even if the old set transfers in
    // the same cycle.
    valid_d   = win_end | (valid_q & ~xfer);
    // Overrun only when an untransferred set is overwritten.
    overrun_d = overrun_q | (win_end & valid_q & ~meas.duty_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= '0;
      prev_q      <= '0;
      edge_seen_q <= '0;
      active_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        acc_q[ch]  <= '0;
        duty_q[ch] <= '0;
      end
    end else begin
      win_cnt_q   <= win_cnt_d;
      prev_q      <= s;
      edge_seen_q <= edge_seen_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      for (int ch = 0; ch < 3; ch++) begin
        acc_q[ch]  <= acc_d[ch];
        duty_q[ch] <= duty_d[ch];
      end
    end
  end

  assign meas.duty_r     = duty_q[2];
  assign meas.duty_g     = duty_q[1];
  assign meas.duty_b     = duty_q[0];
  assign meas.active     = active_q;
  assign meas.duty_valid = valid_q;
  assign meas.overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Testbench for pwm_decoder: table-driven steady-state duty vectors, a reference model
// feeding a scoreboard queue checked on every transfer, and hand-written handshake and
// reset sequences.
module tb_pwm_decoder;
  localparam int unsigned I  = 1200;
  localparam int unsigned CW = 11;
`ifdef PWM_DECODER_SYNC_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 0;
`endif

  typedef logic [3*CW+2:0] exp_t;  // {duty_r, duty_g, duty_b, active}
  typedef struct {
    int             r_hi;
    int             g_hi;
    int             b_hi;
    logic [CW-1:0]  er;
    logic [CW-1:0]  eg;
    logic [CW-1:0]  eb;
    logic [2:0]     ea;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [2:0] pwm_in = 3'b111;
  int         r_hi   = 1200;
  int         g_hi   = 1200;
  int         b_hi   = 1200;
  int         ph     = 0;
  int         errors = 0;
  int         checks = 0;

  // Reference model state.
  exp_t          sb_q[$];
  exp_t          ex;
  logic          exp_ovr = 1'b0;
  int            m_cur   = 0;
  logic [CW-1:0] m_acc [3];
  logic [CW-1:0] m_sum [3];
  logic [2:0]    m_prev, m_seen, m_sh1, m_sh2, m_s, m_e;

  vec_t vecs [5];

  pwm_decoder_if #(.CNT_W(CW)) bus ();

  pwm_decoder #(
    .PWM_INTERVAL(I),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .meas  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Free-running PWM source with a period of exactly one window.
  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      ph     = (ph == int'(I) - 1) ? 0 : ph + 1;
      pwm_in = {ph < r_hi, ph < g_hi, ph < b_hi};
    end
  end

  // Model: runs at each falling edge, mirroring what the DUT sees at the next rising edge.
  initial begin : model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        exp_ovr = 1'b0;
        m_cur   = 0;
        m_prev  = '0;
        m_seen  = '0;
        m_sh1   = '0;
        m_sh2   = '0;
        for (int ch = 0; ch < 3; ch++) m_acc[ch] = '0;
      end else begin
        check("valid_overrun", {bus.duty_valid, bus.overrun}, {sb_q.size() != 0, exp_ovr});
        if (bus.duty_valid && bus.duty_ready && sb_q.size() != 0) begin
          ex = sb_q.pop_front();
          check("xfer_data", {bus.duty_r, bus.duty_g, bus.duty_b, bus.active}, ex);
        end
        m_s = (LAT == 0) ? pwm_in : m_sh2;
        m_e = m_s ^ m_prev;
        for (int ch = 0; ch < 3; ch++) m_sum[ch] = m_acc[ch] + CW'(m_s[ch]);
        if (m_cur == int'(I) - 1) begin
          if (sb_q.size() != 0) begin
            ex      = sb_q.pop_front();
            exp_ovr = 1'b1;
          end
          sb_q.push_back({m_sum[2], m_sum[1], m_sum[0], m_seen | m_e});
          for (int ch = 0; ch < 3; ch++) m_acc[ch] = '0;
          m_seen = '0;
          m_cur  = 0;
        end else begin
          for (int ch = 0; ch < 3; ch++) m_acc[ch] = m_sum[ch];
          m_seen = m_seen | m_e;
          m_cur  = m_cur + 1;
        end
        m_prev = m_s;
        m_sh2  = m_sh1;
        m_sh1  = pwm_in;
      end
    end
  end

  // Returns at the first falling edge with duty_valid high.
  task automatic wait_valid(input string name);
    for (int n = 0; n < 2 * int'(I); n++) begin
      @(negedge clk);
      if (bus.duty_valid) return;
    end
    timeout(name);
  endtask

  // Returns #1 after a rising edge once the DUT's window counter equals target.
  task automatic wait_cur(input int target, input string name);
    for (int n = 0; n < 2 * int'(I); n++) begin
      @(posedge clk);
      #1;
      if (m_cur == target) return;
    end
    timeout(name);
  endtask

  task automatic set_pattern(input vec_t v);
    r_hi = v.r_hi;
    g_hi = v.g_hi;
    b_hi = v.b_hi;
  endtask

  initial begin : stim
    int n;
    vecs[0] = '{1200, 1200, 1200, 11'd1200, 11'd1200, 11'd1200, 3'b000};
    vecs[1] = '{0,    0,    0,    11'd0,    11'd0,    11'd0,    3'b000};
    vecs[2] = '{300,  600,  0,    11'd300,  11'd600,  11'd0,    3'b110};
    vecs[3] = '{1,    1199, 600,  11'd1,    11'd1199, 11'd600,  3'b111};
    vecs[4] = '{900,  0,    1200, 11'd900,  11'd0,    11'd1200, 3'b100};

    bus.duty_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_duty", {bus.duty_r, bus.duty_g, bus.duty_b}, '0);
    check("reset_flags", {bus.active, bus.duty_valid, bus.overrun}, '0);
    rst_n = 1'b1;

    // All channels held high from reset.
    wait_valid("first_window");
    check("first_duty_r", bus.duty_r, I - LAT);
    check("first_duty_b", bus.duty_b, I - LAT);
    check("first_active", bus.active, 3'b111);
    wait_valid("second_window");
    check("second_duty_g", bus.duty_g, I);
    check("second_active", bus.active, 3'b000);

    // Steady-state vectors: the second window after a change is fully steady.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      set_pattern(vecs[i]);
      wait_valid("vec_mixed");
      wait_valid("vec_steady");
      check($sformatf("vec%0d_duty_r", i), bus.duty_r, vecs[i].er);
      check($sformatf("vec%0d_duty_g", i), bus.duty_g, vecs[i].eg);
      check($sformatf("vec%0d_duty_b", i), bus.duty_b, vecs[i].eb);
      check($sformatf("vec%0d_active", i), bus.active, vecs[i].ea);
    end

    // Ready pulsed exactly in the window-end cycle while a set is pending.
    @(posedge clk);
    #1;
    bus.duty_ready = 1'b0;
    set_pattern(vecs[2]);
    wait_cur(int'(I) - 1, "pulse_end1");
    wait_cur(int'(I) - 1, "pulse_end2");
    check("pulse_pending_valid", bus.duty_valid, 1'b1);
    bus.duty_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.duty_ready = 1'b0;
    check("pulse_valid_kept", bus.duty_valid, 1'b1);
    check("pulse_no_overrun", bus.overrun, 1'b0);
    check("pulse_new_r", bus.duty_r, vecs[2].er);
    check("pulse_new_g", bus.duty_g, vecs[2].eg);
    bus.duty_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Ready held low across two window ends.
    bus.duty_ready = 1'b0;
    set_pattern(vecs[3]);
    wait_cur(int'(I) - 1, "ovr_end1");
    wait_cur(int'(I) - 1, "ovr_end2");
    @(posedge clk);
    #1;
    check("ovr_valid", bus.duty_valid, 1'b1);
    check("ovr_flag", bus.overrun, 1'b1);
    check("ovr_data", {bus.duty_r, bus.duty_g, bus.duty_b},
          {vecs[3].er, vecs[3].eg, vecs[3].eb});
    bus.duty_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_sticky", bus.overrun, 1'b1);
    check("ovr_valid_cleared", bus.duty_valid, 1'b0);

    // Reset mid-window.
    wait_cur(700, "reset_at_700");
    rst_n = 1'b0;
    #1;
    check("midrst_duty", {bus.duty_r, bus.duty_g, bus.duty_b}, '0);
    check("midrst_flags", {bus.active, bus.duty_valid, bus.overrun}, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 2 * int'(I); k++) begin
      @(negedge clk);
      n++;
      if (bus.duty_valid) break;
    end
    check("midrst_valid_delay", n, I + 1);
    check("midrst_overrun", bus.overrun, 1'b0);
    wait_valid("post_reset_window");
    check("post_reset_r", bus.duty_r, vecs[3].er);
    check("post_reset_active", bus.active, vecs[3].ea);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
